friscv_wb_arbiter: RTL and testbench



---
 rtl/friscv_wb_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_friscv_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_wb_arbiter.sv
// friscv_wb_arbiter
//   Shares the single register-file write port between NB_UNIT execution units.
//   Each unit pushes rd writes into a private FIFO. A round-robin arbiter pops
//   one entry per cycle into a grant register. The grant register then feeds
//   the registered register-file write stage. Minimum strobe-to-write latency
//   is two cycles. Per-register pending counters export a "no write in flight"
//   status to the issue logic.
//
// Ports
//   aclk, areset   clock, asynchronous active-high reset
//   unit_rd_wr     per-unit write strobe
//   unit_rd_addr   per-unit destination register (5 bits each)
//   unit_rd_val    per-unit write data (XLEN bits each)
//   unit_rd_strb   per-unit byte strobes (XLEN/8 bits each)
//   unit_full      unit FIFO holds FIFO_DEPTH entries
//   wb_overflow    sticky: a strobe was dropped because its FIFO was full
//   rf_rd_*        register-file write port
//   wb_regs_sts    bit r = 1 when no write to xr is queued or in flight
module friscv_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NB_UNIT    = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int NB_INT_REG = 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NB_UNIT-1:0]        unit_rd_wr,
    input  logic [NB_UNIT*5-1:0]      unit_rd_addr,
    input  logic [NB_UNIT*XLEN-1:0]   unit_rd_val,
    input  logic [NB_UNIT*XLEN/8-1:0] unit_rd_strb,
    output logic [NB_UNIT-1:0]        unit_full,
    output logic [NB_UNIT-1:0]        wb_overflow,
    output logic                      rf_rd_wr,
    output logic [4:0]                rf_rd_addr,
    output logic [XLEN-1:0]           rf_rd_val,
    output logic [XLEN/8-1:0]         rf_rd_strb,
    output logic [NB_INT_REG-1:0]     wb_regs_sts
);

    localparam int SW = XLEN / 8;
    localparam int PW = $clog2(NB_UNIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // FIFOs plus the grant and output stages can all hold the same rd.
    localparam int PEND_W = $clog2(NB_UNIT * FIFO_DEPTH + 3);

    logic [4:0]      fifo_addr [NB_UNIT][FIFO_DEPTH];
    logic [XLEN-1:0] fifo_val  [NB_UNIT][FIFO_DEPTH];
    logic [SW-1:0]   fifo_strb [NB_UNIT][FIFO_DEPTH];
    logic [AW-1:0]   wptr_q    [NB_UNIT];
    logic [AW-1:0]   rptr_q    [NB_UNIT];
    logic [CW-1:0]   count_q   [NB_UNIT];

    logic [NB_UNIT-1:0] strobe;
    logic [NB_UNIT-1:0] push;
    logic [NB_UNIT-1:0] pop;
    logic [NB_UNIT-1:0] ovf_q;

    logic [PW-1:0]   ptr_q;
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic [4:0]      head_addr;
    logic [XLEN-1:0] head_val;
    logic [SW-1:0]   head_strb;

    logic            gnt_vld_q;
    logic [4:0]      gnt_addr_q;
    logic [XLEN-1:0] gnt_val_q;
    logic [SW-1:0]   gnt_strb_q;

    logic [PEND_W-1:0] pend_q [NB_INT_REG];
    logic [PEND_W-1:0] pend_d [NB_INT_REG];

    assign wb_overflow = ovf_q;

    always_comb begin
        for (int i = 0; i < NB_UNIT; i++) begin
            unit_full[i] = (count_q[i] == CW'(FIFO_DEPTH));
        end
    end

    // Round-robin search starting at ptr_q, wrapping NB_UNIT-1 -> 0.
    always_comb begin
        int u;
        u       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NB_UNIT; k++) begin
            u = int'(ptr_q) + k;
            if (u >= NB_UNIT) u = u - NB_UNIT;
            if (!gnt_vld && count_q[u] != '0) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(u);
            end
        end
    end

    assign head_addr = fifo_addr[gnt_idx][rptr_q[gnt_idx]];
    assign head_val  = fifo_val[gnt_idx][rptr_q[gnt_idx]];
    assign head_strb = fifo_strb[gnt_idx][rptr_q[gnt_idx]];

    // A full FIFO still accepts a strobe when it is popped in the same cycle.
    always_comb begin
        for (int i = 0; i < NB_UNIT; i++) begin
            strobe[i] = unit_rd_wr[i] && (unit_rd_addr[i*5 +: 5] != 5'd0);
            pop[i]    = gnt_vld && (gnt_idx == PW'(i));
            push[i]   = strobe[i] && (!unit_full[i] || pop[i]);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NB_UNIT; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NB_UNIT; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
                if (pop[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
                count_q[i] <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
                if (strobe[i] && unit_full[i] && !pop[i]) ovf_q[i] <= 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < NB_UNIT; i++) begin
            if (push[i]) begin
                fifo_addr[i][wptr_q[i]] <= unit_rd_addr[i*5 +: 5];
                fifo_val[i][wptr_q[i]]  <= unit_rd_val[i*XLEN +: XLEN];
                fifo_strb[i][wptr_q[i]] <= unit_rd_strb[i*SW +: SW];
            end
        end
    end

    // Grant register followed by the register-file write stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr_q      <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_addr_q <= '0;
            gnt_val_q  <= '0;
            gnt_strb_q <= '0;
            rf_rd_wr   <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_val  <= '0;
            rf_rd_strb <= '0;
        end else begin
            gnt_vld_q <= gnt_vld;
            if (gnt_vld) begin
                ptr_q      <= (gnt_idx == PW'(NB_UNIT - 1)) ? '0 : gnt_idx + PW'(1);
                gnt_addr_q <= head_addr;
                gnt_val_q  <= head_val;
                gnt_strb_q <= head_strb;
            end
            rf_rd_wr <= gnt_vld_q;
            if (gnt_vld_q) begin
                rf_rd_addr <= gnt_addr_q;
                rf_rd_val  <= gnt_val_q;
                rf_rd_strb <= gnt_strb_q;
            end
        end
    end

    // Pending counters: +1 per accepted push, -1 per register-file write.
    always_comb begin
        logic [PEND_W-1:0] acc;
        acc = '0;
        for (int r = 0; r < NB_INT_REG; r++) begin
            acc = pend_q[r];
            for (int i = 0; i < NB_UNIT; i++) begin
                if (push[i] && unit_rd_addr[i*5 +: 5] == 5'(r)) acc = acc + PEND_W'(1);
            end
            if (rf_rd_wr && rf_rd_addr == 5'(r)) acc = acc - PEND_W'(1);
            pend_d[r] = acc;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int r = 0; r < NB_INT_REG; r++) pend_q[r] <= '0;
        end else begin
            for (int r = 0; r < NB_INT_REG; r++) pend_q[r] <= pend_d[r];
        end
    end

    always_comb begin
        wb_regs_sts = '1;
        for (int r = 1; r < NB_INT_REG; r++) begin
            wb_regs_sts[r] = (pend_q[r] == '0);
        end
    end

endmodule

// File: tb/tb_friscv_wb_arbiter.sv
module tb_friscv_wb_arbiter;

    localparam int XLEN       = 32;
    localparam int NB_UNIT    = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int NB_INT_REG = 32;
    localparam int SW         = XLEN / 8;

    typedef struct packed {
        logic [4:0]      addr;
        logic [XLEN-1:0] val;
        logic [SW-1:0]   strb;
    } ent_t;

    logic                    aclk = 1'b0;
    logic                    areset;
    logic [NB_UNIT-1:0]      unit_rd_wr;
    logic [NB_UNIT*5-1:0]    unit_rd_addr;
    logic [NB_UNIT*XLEN-1:0] unit_rd_val;
    logic [NB_UNIT*SW-1:0]   unit_rd_strb;
    logic [NB_UNIT-1:0]      unit_full;
    logic [NB_UNIT-1:0]      wb_overflow;
    logic                    rf_rd_wr;
    logic [4:0]              rf_rd_addr;
    logic [XLEN-1:0]         rf_rd_val;
    logic [SW-1:0]           rf_rd_strb;
    logic [NB_INT_REG-1:0]   wb_regs_sts;

    friscv_wb_arbiter #(
        .XLEN       (XLEN),
        .NB_UNIT    (NB_UNIT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .NB_INT_REG (NB_INT_REG)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .unit_rd_wr   (unit_rd_wr),
        .unit_rd_addr (unit_rd_addr),
        .unit_rd_val  (unit_rd_val),
        .unit_rd_strb (unit_rd_strb),
        .unit_full    (unit_full),
        .wb_overflow  (wb_overflow),
        .rf_rd_wr     (rf_rd_wr),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_val    (rf_rd_val),
        .rf_rd_strb   (rf_rd_strb),
        .wb_regs_sts  (wb_regs_sts)
    );

    always #5 aclk = ~aclk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Reference model: queues per unit, a two-deep delay line to the
    // register file, and a count of outstanding writes per register.
    ent_t mq [NB_UNIT][$];
    int   m_ptr;
    bit   m_ovf [NB_UNIT];
    int   m_pend [NB_INT_REG];
    bit   s1_v, rf_v;
    ent_t s1_e, rf_e;

    task automatic model_reset();
        for (int i = 0; i < NB_UNIT; i++) begin
            mq[i].delete();
            m_ovf[i] = 0;
        end
        for (int r = 0; r < NB_INT_REG; r++) m_pend[r] = 0;
        m_ptr = 0;
        s1_v  = 0;
        rf_v  = 0;
    endtask

    task automatic model_edge();
        int   g;
        bit   gv;
        int   pre [NB_UNIT];
        ent_t ne;
        gv = 0;
        g  = 0;
        for (int i = 0; i < NB_UNIT; i++) pre[i] = mq[i].size();
        for (int k = 0; k < NB_UNIT; k++) begin
            int u;
            u = (m_ptr + k) % NB_UNIT;
            if (!gv && pre[u] != 0) begin
                gv = 1;
                g  = u;
            end
        end
        if (rf_v) m_pend[rf_e.addr]--;
        rf_v = s1_v;
        rf_e = s1_e;
        s1_v = gv;
        if (gv) begin
            s1_e  = mq[g].pop_front();
            m_ptr = (g + 1) % NB_UNIT;
        end
        for (int i = 0; i < NB_UNIT; i++) begin
            ne.addr = unit_rd_addr[i*5 +: 5];
            ne.val  = unit_rd_val[i*XLEN +: XLEN];
            ne.strb = unit_rd_strb[i*SW +: SW];
            if (unit_rd_wr[i] && ne.addr != 0) begin
                if (pre[i] < FIFO_DEPTH || (gv && g == i)) begin
                    mq[i].push_back(ne);
                    m_pend[ne.addr]++;
                end else begin
                    m_ovf[i] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NB_UNIT-1:0]    ef, eo;
        logic [NB_INT_REG-1:0] es;
        for (int i = 0; i < NB_UNIT; i++) begin
            ef[i] = (mq[i].size() == FIFO_DEPTH);
            eo[i] = m_ovf[i];
        end
        for (int r = 0; r < NB_INT_REG; r++) es[r] = (r == 0) || (m_pend[r] == 0);
        check("rf_rd_wr", 64'(rf_rd_wr), 64'(rf_v));
        if (rf_v) begin
            check("rf_rd_addr", 64'(rf_rd_addr), 64'(rf_e.addr));
            check("rf_rd_val", 64'(rf_rd_val), 64'(rf_e.val));
            check("rf_rd_strb", 64'(rf_rd_strb), 64'(rf_e.strb));
        end
        check("unit_full", 64'(unit_full), 64'(ef));
        check("wb_overflow", 64'(wb_overflow), 64'(eo));
        check("wb_regs_sts", 64'(wb_regs_sts), 64'(es));
    endtask

    task automatic cycle(input logic [NB_UNIT-1:0] wr, input logic [NB_UNIT*5-1:0] ad,
                         input logic [NB_UNIT*XLEN-1:0] vl, input logic [NB_UNIT*SW-1:0] sb);
        @(negedge aclk);
        unit_rd_wr   = wr;
        unit_rd_addr = ad;
        unit_rd_val  = vl;
        unit_rd_strb = sb;
        @(posedge aclk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0, '0, '0, '0);
    endtask

    task automatic rand_cycle(input int rate, input int amax, input bit honor_full);
        logic [NB_UNIT-1:0]      wr;
        logic [NB_UNIT*5-1:0]    ad;
        logic [NB_UNIT*XLEN-1:0] vl;
        logic [NB_UNIT*SW-1:0]   sb;
        for (int i = 0; i < NB_UNIT; i++) begin
            wr[i] = ($urandom_range(0, 99) < rate);
            if (honor_full && mq[i].size() == FIFO_DEPTH) wr[i] = 1'b0;
            ad[i*5 +: 5]       = 5'($urandom_range(0, amax));
            vl[i*XLEN +: XLEN] = XLEN'($urandom);
            sb[i*SW +: SW]     = SW'($urandom_range(0, 15));
        end
        cycle(wr, ad, vl, sb);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2;
        areset       = 1'b1;
        unit_rd_wr   = '0;
        unit_rd_addr = '0;
        unit_rd_val  = '0;
        unit_rd_strb = '0;
        #1;
        model_reset();
        check("rst_rf_wr", 64'(rf_rd_wr), 64'd0);
        check("rst_rf_addr", 64'(rf_rd_addr), 64'd0);
        check("rst_rf_val", 64'(rf_rd_val), 64'd0);
        check("rst_full", 64'(unit_full), 64'd0);
        check("rst_ovf", 64'(wb_overflow), 64'd0);
        check("rst_sts", 64'(wb_regs_sts), 64'hFFFF_FFFF);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        areset       = 1'b1;
        unit_rd_wr   = '0;
        unit_rd_addr = '0;
        unit_rd_val  = '0;
        unit_rd_strb = '0;
        model_reset();
        do_reset();

        // Minimum latency: strobe at E0, write visible after E2, status clears after E3.
        cycle(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, {4'h0, 4'hF, 4'h0});
        check("lat_sts5_busy", 64'(wb_regs_sts[5]), 64'd0);
        idle(1);
        check("lat_e1_wr", 64'(rf_rd_wr), 64'd0);
        idle(1);
        check("lat_e2_wr", 64'(rf_rd_wr), 64'd1);
        check("lat_e2_addr", 64'(rf_rd_addr), 64'd5);
        check("lat_e2_val", 64'(rf_rd_val), 64'hDEADBEEF);
        check("lat_e2_sts5", 64'(wb_regs_sts[5]), 64'd0);
        idle(1);
        check("lat_e3_sts5", 64'(wb_regs_sts[5]), 64'd1);
        check("lat_e3_wr", 64'(rf_rd_wr), 64'd0);

        // Round-robin from pointer 0, twice.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 12'hFFF);
            idle(1);
            for (int k = 1; k <= 3; k++) begin
                idle(1);
                check("rr_wr", 64'(rf_rd_wr), 64'd1);
                check("rr_addr", 64'(rf_rd_addr), 64'(k));
            end
            idle(2);
        end

        // x0 is dropped; duplicate rd keeps status low until the last write.
        cycle(3'b001, '0, {64'h0, 32'h1234}, 12'h00F);
        check("x0_sts", 64'(wb_regs_sts), 64'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("x0_no_wr", 64'(rf_rd_wr), 64'd0);
        end
        cycle(3'b001, {10'd0, 5'd9}, {64'h0, 32'hA1}, 12'h00F);
        cycle(3'b001, {10'd0, 5'd9}, {64'h0, 32'hA2}, 12'h00F);
        idle(1);
        check("dup_first_val", 64'(rf_rd_val), 64'hA1);
        idle(1);
        check("dup_second_val", 64'(rf_rd_val), 64'hA2);
        check("dup_sts9_busy", 64'(wb_regs_sts[9]), 64'd0);
        idle(1);
        check("dup_sts9_free", 64'(wb_regs_sts[9]), 64'd1);

        // Random traffic honouring unit_full.
        for (int k = 0; k < 300; k++) rand_cycle(50, 7, 1'b1);
        idle(10);

        // Heavy traffic ignoring unit_full, with a reset in the middle.
        for (int k = 0; k < 100; k++) rand_cycle(90, 31, 1'b0);
        do_reset();
        for (int k = 0; k < 150; k++) rand_cycle(90, 7, 1'b0);
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
